glm_dot_multi: RTL and testbench
================================

# glm_dot_multi

Parametrised multi-channel dot-product engine for the GLM pipeline. It streams feature lines from an input FIFO and computes NUM_CHANNELS dot products in parallel against model vectors held in a wide BRAM. An optional per-lane label subtraction is applied to the model before the multiply. It processes a batch of samples per command, emits one packed result word per sample, and honours output backpressure.

## Interface
- LANES, 16, values per line
- DATA_W, 16, signed two's-complement width of each value
- NUM_CHANNELS, 2, model vectors evaluated in parallel
- ACC_W, 32, signed result width per channel
- ADDR_W, 16, BRAM address width
- clk in 1: the single clock
- resetn in 1: reset, asynchronous and active-low
- op_start in 1: command pulse, sampled in IDLE only
- cfg_num_lines in 16: lines per sample
- cfg_num_samples in 16: samples per command
- cfg_model_offset in ADDR_W: model base address
- cfg_label_offset in ADDR_W: label base address
- cfg_subtract in 1: subtract labels from model before multiply
- busy out 1: high whenever state is not IDLE
- op_done out 1: one-cycle completion pulse
- in_empty in 1: input FIFO empty
- in_re out 1: input FIFO read
- in_rdata in LANES*DATA_W: input line, valid the cycle after in_re
- model_re out 1: model BRAM read
- model_raddr out ADDR_W: model BRAM address
- model_rdata in NUM_CHANNELS*LANES*DATA_W: model data; channel c occupies slice c; valid the cycle after model_re
- label_re out 1: label BRAM read
- label_raddr out ADDR_W: label BRAM address
- label_rdata in LANES*DATA_W: label data, valid the cycle after label_re
- out_afull in 1: output FIFO has fewer than 4 free entries
- out_we out 1: output write
- out_wdata out NUM_CHANNELS*ACC_W: per-channel results; channel c occupies slice c

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE: on op_start with both counts nonzero. All cfg_* inputs are latched. Line, sample and global-line counters are cleared.
- IDLE -> DONE: on op_start with either count zero. No reads and no writes occur.
- op_start outside IDLE is ignored.
- Issue cycle: in ISSUE, when in_empty=0 and out_afull=0, the block asserts in_re, model_re and label_re together.
  - model_raddr = model_offset + line_idx. The model is reused for every sample.
  - label_raddr = label_offset + global_line. global_line increments on every issue, never resets within a command, and wraps mod 2^ADDR_W. Address sums also wrap mod 2^ADDR_W.
  - line_idx wraps to 0 after num_lines-1, and the sample counter then increments.
  - label_re is asserted even when cfg_subtract=0. Its data is then ignored.
- ISSUE -> DRAIN: after the issue of the last line of the last sample.
- DRAIN -> IDLE: on the final out_we. op_done is asserted in that same cycle.
- DONE -> IDLE: after one cycle, with op_done=1 during that cycle.
- Arithmetic, per lane and channel:
  - operand m = model value when cfg_subtract=0.
  - operand m = model - label, at DATA_W+1 bits, when cfg_subtract=1.
  - The product m*x is exact at 2*DATA_W+2 bits.
  - Lane sums are exact.
  - Accumulation is sign-extended or truncated to ACC_W and wraps mod 2^ACC_W.
- The accumulator clears at each sample's first line. One out_we is produced per sample, carrying all channels.

## Timing
- Pipeline for a line issued at cycle t:
  - t+1: read data arrives.
  - t+2: products registered.
  - t+3: lane sums registered.
  - t+4: accumulator updated.
- For the last line of a sample, out_we=1 at t+4, with out_wdata holding the completed sums.
- Sustained throughput is one line per cycle while in_empty=0 and out_afull=0.
- Backpressure:
  - out_afull=1 blocks new issues only. In-flight lines complete and write.
  - The downstream FIFO must absorb up to 4 writes after out_afull rises. No result is ever dropped.
- Reset values: busy=0, op_done=0, in_re=0, model_re=0, label_re=0, out_we=0, model_raddr=0, label_raddr=0, out_wdata=0. State is IDLE.
- Reset mid-operation:
  - Reset clears all pipeline valid bits asynchronously.
  - No out_we or op_done is produced after reset deassertion until a new op_start.
  - The latched config is discarded.

## Test plan
- Basic dot product: LANES=16; x=1 in every lane; channel 0 model=2, channel 1 model=-1; num_lines=3, num_samples=1, back-to-back data -> one out_we with ch0=96, ch1=-48. out_we is 4 cycles after the third issue, and op_done is in the same cycle.
- Subtract mode: model=5, label=3, x=2, num_lines=1, cfg_subtract=1 -> ch0=64. With cfg_subtract=0 and the same data -> ch0=160.
- Batch addressing: num_lines=2, num_samples=3, both offsets 10:
  - model_raddr sequence is 10,11,10,11,10,11.
  - label_raddr sequence is 10..15.
  - Exactly 3 out_we and 1 op_done.
- Backpressure: out_afull held high for 20 cycles mid-sample -> no in_re in that window. Writes already in flight still occur. Final results are identical to the unstalled run.
- Boundaries:
  - num_lines=0 -> op_done the cycle after op_start, with no reads and no writes.
  - x=model=-32768 in all 16 lanes, 1 line -> ch0 = 2^34 mod 2^32 = 0.
- Reset: assert resetn=0 two cycles after the second issue of a 4-line command -> all outputs 0 immediately. After release, no out_we occurs, and a fresh command then completes correctly.

Source files
------------

// File: rtl/glm_dot_multi_if.sv
// Bus bundle for glm_dot_multi: command/config, input FIFO, model and label
// BRAM read ports, and output FIFO write port.
`timescale 1ns/1ps
interface glm_dot_multi_if #(
    parameter int LANES        = 16,
    parameter int DATA_W       = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int ACC_W        = 32,
    parameter int ADDR_W       = 16
);
    logic                                 op_start;
    logic [15:0]                          cfg_num_lines;
    logic [15:0]                          cfg_num_samples;
    logic [ADDR_W-1:0]                    cfg_model_offset;
    logic [ADDR_W-1:0]                    cfg_label_offset;
    logic                                 cfg_subtract;
    logic                                 busy;
    logic                                 op_done;

    logic                                 in_empty;
    logic                                 in_re;
    logic [LANES*DATA_W-1:0]              in_rdata;

    logic                                 model_re;
    logic [ADDR_W-1:0]                    model_raddr;
    logic [NUM_CHANNELS*LANES*DATA_W-1:0] model_rdata;

    logic                                 label_re;
    logic [ADDR_W-1:0]                    label_raddr;
    logic [LANES*DATA_W-1:0]              label_rdata;

    logic                                 out_afull;
    logic                                 out_we;
    logic [NUM_CHANNELS*ACC_W-1:0]        out_wdata;

    modport master (
        output op_start, cfg_num_lines, cfg_num_samples, cfg_model_offset,
               cfg_label_offset, cfg_subtract, in_empty, in_rdata,
               model_rdata, label_rdata, out_afull,
        input  busy, op_done, in_re, model_re, model_raddr, label_re,
               label_raddr, out_we, out_wdata
    );

    modport slave (
        input  op_start, cfg_num_lines, cfg_num_samples, cfg_model_offset,
               cfg_label_offset, cfg_subtract, in_empty, in_rdata,
               model_rdata, label_rdata, out_afull,
        output busy, op_done, in_re, model_re, model_raddr, label_re,
               label_raddr, out_we, out_wdata
    );
endinterface

// File: rtl/glm_dot_multi.sv
// Multi-channel dot-product engine: streams feature lines, multiplies them
// against NUM_CHANNELS model vectors (optionally minus labels) and emits one
// packed per-channel accumulation per sample.
`timescale 1ns/1ps
module glm_dot_multi #(
    parameter int LANES        = 16,
    parameter int DATA_W       = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int ACC_W        = 32,
    parameter int ADDR_W       = 16
) (
    input  logic          clk,
    input  logic          resetn,
    glm_dot_multi_if.slave bus
);
    localparam int PROD_W = 2*DATA_W + 2;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int EXT_W  = (SUM_W > ACC_W) ? SUM_W : ACC_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state;

    logic [15:0]       num_lines, num_samples;
    logic [15:0]       line_idx, sample_idx;
    logic [ADDR_W-1:0] model_off, label_off, global_line;
    logic              subtract;

    logic issue, line_last, sample_last;
    logic v1, v2, v3;
    logic first1, first2, first3;
    logic last1, last2, last3;
    logic fin1, fin2, fin3;
    logic out_we_q, op_done_q;

    logic signed [DATA_W-1:0] x_op     [LANES];
    logic signed [DATA_W:0]   m_op     [NUM_CHANNELS][LANES];
    logic signed [PROD_W-1:0] prod_q   [NUM_CHANNELS][LANES];
    logic signed [SUM_W-1:0]  lane_sum [NUM_CHANNELS];
    logic signed [SUM_W-1:0]  sum_q    [NUM_CHANNELS];
    logic [ACC_W-1:0]         sum_acc  [NUM_CHANNELS];
    logic [NUM_CHANNELS*ACC_W-1:0] acc;

    assign issue       = (state == ISSUE) && !bus.in_empty && !bus.out_afull;
    assign line_last   = (line_idx == num_lines - 16'd1);
    assign sample_last = (sample_idx == num_samples - 16'd1);

    assign bus.in_re       = issue;
    assign bus.model_re    = issue;
    assign bus.label_re    = issue;
    assign bus.model_raddr = issue ? model_off + ADDR_W'(line_idx) : '0;
    assign bus.label_raddr = issue ? label_off + global_line : '0;
    assign bus.busy        = (state != IDLE);
    assign bus.op_done     = op_done_q;
    assign bus.out_we      = out_we_q;
    assign bus.out_wdata   = acc;

    // Command FSM: config latch, line/sample/global counters, completion pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            num_lines   <= '0;
            num_samples <= '0;
            model_off   <= '0;
            label_off   <= '0;
            subtract    <= 1'b0;
            line_idx    <= '0;
            sample_idx  <= '0;
            global_line <= '0;
            op_done_q   <= 1'b0;
        end else begin
            op_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.op_start) begin
                        num_lines   <= bus.cfg_num_lines;
                        num_samples <= bus.cfg_num_samples;
                        model_off   <= bus.cfg_model_offset;
                        label_off   <= bus.cfg_label_offset;
                        subtract    <= bus.cfg_subtract;
                        line_idx    <= '0;
                        sample_idx  <= '0;
                        global_line <= '0;
                        if (bus.cfg_num_lines == '0 || bus.cfg_num_samples == '0) begin
                            state     <= DONE;
                            op_done_q <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        global_line <= global_line + ADDR_W'(1);
                        if (line_last) begin
                            line_idx   <= '0;
                            sample_idx <= sample_idx + 16'd1;
                            if (sample_last) state <= DRAIN;
                        end else begin
                            line_idx <= line_idx + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (v3 && fin3) begin
                        state     <= IDLE;
                        op_done_q <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand formation: sign-extend model to DATA_W+1 and optionally subtract label
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            x_op[l] = bus.in_rdata[l*DATA_W +: DATA_W];
        end
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                m_op[c][l] = (DATA_W+1)'(signed'(bus.model_rdata[(c*LANES+l)*DATA_W +: DATA_W]));
                if (subtract) begin
                    m_op[c][l] = m_op[c][l]
                               - (DATA_W+1)'(signed'(bus.label_rdata[l*DATA_W +: DATA_W]));
                end
            end
        end
    end

    // Exact lane reduction, then fit to ACC_W (sign-extend or truncate)
    always_comb begin
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            lane_sum[c] = '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                lane_sum[c] = lane_sum[c] + SUM_W'(prod_q[c][l]);
            end
            sum_acc[c] = ACC_W'(EXT_W'(sum_q[c]));
        end
    end

    // Datapath registers: products at t+2, lane sums at t+3
    always_ff @(posedge clk) begin
        if (v1) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    prod_q[c][l] <= PROD_W'(m_op[c][l]) * PROD_W'(x_op[l]);
                end
            end
        end
        if (v2) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                sum_q[c] <= lane_sum[c];
            end
        end
    end

    // Pipeline valid/position tags and wrapping accumulator with sample write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            first1 <= 1'b0; first2 <= 1'b0; first3 <= 1'b0;
            last1 <= 1'b0; last2 <= 1'b0; last3 <= 1'b0;
            fin1 <= 1'b0; fin2 <= 1'b0; fin3 <= 1'b0;
            out_we_q <= 1'b0;
            acc      <= '0;
        end else begin
            v1     <= issue;
            first1 <= issue && (line_idx == '0);
            last1  <= issue && line_last;
            fin1   <= issue && line_last && sample_last;
            v2 <= v1; first2 <= first1; last2 <= last1; fin2 <= fin1;
            v3 <= v2; first3 <= first2; last3 <= last2; fin3 <= fin2;
            out_we_q <= v3 && last3;
            if (v3) begin
                for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                    acc[c*ACC_W +: ACC_W] <= first3 ? sum_acc[c]
                                                    : acc[c*ACC_W +: ACC_W] + sum_acc[c];
                end
            end
        end
    end
endmodule

// File: tb/tb_glm_dot_multi.sv
// Directed bench for glm_dot_multi: uniform/ramped line data, hand-computed
// per-channel results, address sequences, timing, backpressure and reset.
`timescale 1ns/1ps
module tb_glm_dot_multi;
    localparam int LANES = 16, DATA_W = 16, NUM_CHANNELS = 2, ACC_W = 32, ADDR_W = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    glm_dot_multi_if #(.LANES(LANES), .DATA_W(DATA_W), .NUM_CHANNELS(NUM_CHANNELS),
                       .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    glm_dot_multi #(.LANES(LANES), .DATA_W(DATA_W), .NUM_CHANNELS(NUM_CHANNELS),
                    .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    int n_rd = 0, n_we = 0, n_done = 0;
    int last_we_cyc = 0, last_done_cyc = 0;
    int rd_cyc_q[$];
    int maddr_q[$];
    int laddr_q[$];
    logic [63:0] wd_q[$];
    int x_base = 0, x_step = 0, m0v = 0, m1v = 0, lblv = 0;
    int op_cyc = 0;
    int rd0 = 0, we0 = 0, done0 = 0;
    int rd_b = 0, we_b = 0;

    function automatic logic [LANES*DATA_W-1:0] pack_line(input int base, input int step);
        logic [LANES*DATA_W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = DATA_W'(base + l*step);
        return r;
    endfunction

    function automatic logic [NUM_CHANNELS*LANES*DATA_W-1:0] pack_model(input int a, input int b);
        logic [NUM_CHANNELS*LANES*DATA_W-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int l = 0; l < LANES; l++)
                r[(c*LANES+l)*DATA_W +: DATA_W] = DATA_W'((c == 0) ? a : b);
        return r;
    endfunction

    function automatic longint ch(input logic [63:0] w, input int c);
        logic signed [31:0] s;
        s = w[c*32 +: 32];
        return longint'(s);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM / FIFO responders: data one cycle after the read strobe, zero otherwise
    always @(posedge clk) begin
        bus.in_rdata    <= bus.in_re    ? pack_line(x_base, x_step) : '0;
        bus.model_rdata <= bus.model_re ? pack_model(m0v, m1v)      : '0;
        bus.label_rdata <= bus.label_re ? pack_line(lblv, 0)        : '0;
    end

    // Event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.in_re) begin
            n_rd <= n_rd + 1;
            rd_cyc_q.push_back(cyc);
        end
        if (bus.model_re) maddr_q.push_back(int'(bus.model_raddr));
        if (bus.label_re) laddr_q.push_back(int'(bus.label_raddr));
        if (bus.out_we) begin
            n_we <= n_we + 1;
            last_we_cyc <= cyc;
            wd_q.push_back(bus.out_wdata);
        end
        if (bus.op_done) begin
            n_done <= n_done + 1;
            last_done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        rd0 = n_rd; we0 = n_we; done0 = n_done;
        rd_cyc_q.delete(); maddr_q.delete(); laddr_q.delete(); wd_q.delete();
    endtask

    task automatic set_data(input int xb, input int xs, input int a, input int b, input int lb);
        x_base = xb; x_step = xs; m0v = a; m1v = b; lblv = lb;
    endtask

    task automatic start_cmd(input int lines, input int samples, input int moff,
                             input int loff, input logic sub);
        bus.cfg_num_lines    = 16'(lines);
        bus.cfg_num_samples  = 16'(samples);
        bus.cfg_model_offset = ADDR_W'(moff);
        bus.cfg_label_offset = ADDR_W'(loff);
        bus.cfg_subtract     = sub;
        bus.op_start         = 1'b1;
        op_cyc = cyc;
        @(posedge clk); #1;
        bus.op_start         = 1'b0;
        bus.cfg_num_lines    = 16'hFFFF;
        bus.cfg_num_samples  = 16'hFFFF;
        bus.cfg_model_offset = 16'h5555;
        bus.cfg_label_offset = 16'h5555;
        bus.cfg_subtract     = ~sub;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == done0; i++) begin
            @(posedge clk); #1;
        end
        check("done_seen", longint'(n_done - done0), 1);
    endtask

    task automatic wait_reads(input int target, input int budget);
        for (int i = 0; i < budget && n_rd < target; i++) begin
            @(posedge clk); #1;
        end
        check("reads_seen", longint'(n_rd >= target), 1);
    endtask

    initial begin
        resetn = 1'b1;
        bus.op_start = 1'b0;
        bus.cfg_num_lines = '0; bus.cfg_num_samples = '0;
        bus.cfg_model_offset = '0; bus.cfg_label_offset = '0; bus.cfg_subtract = 1'b0;
        bus.in_empty = 1'b0;
        bus.out_afull = 1'b0;
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_busy",    longint'(bus.busy), 0);
        check("rst_op_done", longint'(bus.op_done), 0);
        check("rst_in_re",   longint'(bus.in_re), 0);
        check("rst_model_re", longint'(bus.model_re), 0);
        check("rst_label_re", longint'(bus.label_re), 0);
        check("rst_out_we",  longint'(bus.out_we), 0);
        check("rst_maddr",   longint'(bus.model_raddr), 0);
        check("rst_laddr",   longint'(bus.label_raddr), 0);
        check("rst_wdata",   longint'(bus.out_wdata), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Basic: x=1, ch0 model 2, ch1 model -1, 3 lines
        set_data(1, 0, 2, -1, 0);
        snap();
        start_cmd(3, 1, 0, 0, 1'b0);
        wait_done(100);
        check("basic_reads", longint'(n_rd - rd0), 3);
        check("basic_writes", longint'(n_we - we0), 1);
        check("basic_ch0", ch(wd_q[0], 0), 96);
        check("basic_ch1", ch(wd_q[0], 1), -48);
        check("basic_first_issue", longint'(rd_cyc_q[0]), longint'(op_cyc + 1));
        check("basic_latency", longint'(last_we_cyc - rd_cyc_q[2]), 4);
        check("basic_done_with_we", longint'(last_done_cyc), longint'(last_we_cyc));
        check("basic_idle_busy", longint'(bus.busy), 0);

        // Subtract mode and its plain counterpart
        set_data(2, 0, 5, 1, 3);
        snap();
        start_cmd(1, 1, 0, 0, 1'b1);
        wait_done(100);
        check("sub_ch0", ch(wd_q[0], 0), 64);
        check("sub_ch1", ch(wd_q[0], 1), -64);
        snap();
        start_cmd(1, 1, 0, 0, 1'b0);
        wait_done(100);
        check("nosub_ch0", ch(wd_q[0], 0), 160);
        check("nosub_ch1", ch(wd_q[0], 1), 32);

        // Per-lane ramp x=1..16 with negative label
        set_data(1, 1, 2, -3, -1);
        snap();
        start_cmd(1, 1, 0, 0, 1'b1);
        wait_done(100);
        check("ramp_ch0", ch(wd_q[0], 0), 408);
        check("ramp_ch1", ch(wd_q[0], 1), -272);

        // Batch addressing, with an op_start mid-run that must be ignored
        set_data(1, 0, 1, 1, 0);
        snap();
        start_cmd(2, 3, 10, 10, 1'b0);
        wait_reads(rd0 + 1, 50);
        bus.cfg_num_lines = 16'd7;
        bus.op_start = 1'b1;
        @(posedge clk); #1;
        bus.op_start = 1'b0;
        wait_done(100);
        repeat (3) @(posedge clk);
        #1;
        check("batch_reads", longint'(maddr_q.size()), 6);
        for (int i = 0; i < 6 && i < maddr_q.size(); i++) begin
            check($sformatf("batch_maddr%0d", i), longint'(maddr_q[i]), longint'(10 + (i % 2)));
            check($sformatf("batch_laddr%0d", i), longint'(laddr_q[i]), longint'(10 + i));
        end
        check("batch_writes", longint'(n_we - we0), 3);
        check("batch_dones", longint'(n_done - done0), 1);
        check("batch_s0_ch0", ch(wd_q[0], 0), 32);
        check("batch_s2_ch1", ch(wd_q[2], 1), 32);

        // Backpressure: stall 20 cycles after the third issue of a 2x2 command
        set_data(3, 0, 2, -1, 0);
        snap();
        start_cmd(2, 2, 0, 0, 1'b0);
        wait_reads(rd0 + 3, 50);
        bus.out_afull = 1'b1;
        rd_b = n_rd; we_b = n_we;
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_reads", longint'(n_rd - rd_b), 0);
        check("bp_inflight_write", longint'(n_we - we_b), 1);
        bus.out_afull = 1'b0;
        wait_done(100);
        check("bp_writes", longint'(n_we - we0), 2);
        check("bp_s0_ch0", ch(wd_q[0], 0), 192);
        check("bp_s0_ch1", ch(wd_q[0], 1), -96);
        check("bp_s1_ch0", ch(wd_q[1], 0), 192);
        check("bp_s1_ch1", ch(wd_q[1], 1), -96);

        // Zero counts go straight to DONE
        snap();
        start_cmd(0, 1, 0, 0, 1'b0);
        wait_done(20);
        check("zl_done_cycle", longint'(last_done_cyc), longint'(op_cyc + 1));
        check("zl_reads", longint'(n_rd - rd0), 0);
        check("zl_writes", longint'(n_we - we0), 0);
        snap();
        start_cmd(5, 0, 0, 0, 1'b0);
        wait_done(20);
        check("zs_done_cycle", longint'(last_done_cyc), longint'(op_cyc + 1));
        check("zs_reads", longint'(n_rd - rd0), 0);

        // Extreme values
        set_data(-32768, 0, -32768, -32768, 0);
        snap();
        start_cmd(1, 1, 0, 0, 1'b0);
        wait_done(100);
        check("max_ch0", ch(wd_q[0], 0), 0);
        check("max_ch1", ch(wd_q[0], 1), 0);
        set_data(-32768, 0, -32768, 1, 32767);
        snap();
        start_cmd(1, 1, 0, 0, 1'b1);
        wait_done(100);
        check("maxsub_ch0", ch(wd_q[0], 0), -524288);
        check("maxsub_ch1", ch(wd_q[0], 1), -1048576);

        // Reset in the middle of a 4-line command
        set_data(1, 0, 2, -1, 0);
        snap();
        start_cmd(4, 1, 0, 0, 1'b0);
        wait_reads(rd0 + 2, 50);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("mr_busy", longint'(bus.busy), 0);
        check("mr_in_re", longint'(bus.in_re), 0);
        check("mr_out_we", longint'(bus.out_we), 0);
        check("mr_maddr", longint'(bus.model_raddr), 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        we_b = n_we; rd_b = n_done;
        repeat (12) @(posedge clk);
        #1;
        check("mr_no_we", longint'(n_we - we_b), 0);
        check("mr_no_done", longint'(n_done - rd_b), 0);
        snap();
        start_cmd(1, 1, 0, 0, 1'b0);
        wait_done(100);
        check("mr_fresh_ch0", ch(wd_q[0], 0), 32);
        check("mr_fresh_ch1", ch(wd_q[0], 1), -16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
